// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the asynchronous FIFO and the logic that
// surrounds it. This includes the defaults and the FSM state type for the
// write-side arbiter.
//   DATA_WIDTH     : FIFO word width
//   ARB_NUM_REQ    : default number of write requesters
//   ARB_MAX_BURST  : default largest burst length accepted by the arbiter
//   arb_state_t    : arbiter FSM state encoding
//   arb_clamp_len  : limits a requested burst length to the arbiter maximum
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_MAX_BURST = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BURST,
    ARB_DONE
  } arb_state_t;

  // Oversized requests are served as a maximum-length burst instead of
  // being rejected.
  function automatic int arb_clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester side and the FIFO write side of the write arbiter.
//   req       : per-requester burst request (level)
//   burst_len : per-requester burst length, sampled when the grant is issued
//   req_data  : word currently offered by each requester
//   full      : FIFO full flag in the write clock domain
//   wr_en     : FIFO write enable
//   data_in   : FIFO write data
//   grant     : one-hot owner of the write port for the whole burst
//   data_ack  : one-hot; the granted requester's word is written this cycle
//   done      : one-hot, single-cycle end-of-burst pulse
//   busy      : the arbiter is not idle
// Modports:
//   master : the arbiter, which drives the FIFO write port
//   slave  : the requesters and the FIFO, which drive the request side
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = fifo_pkg::ARB_NUM_REQ,
  parameter int BL_W    = $clog2(fifo_pkg::ARB_MAX_BURST + 1)
);
  import fifo_pkg::*;

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][BL_W-1:0]       burst_len;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic                               full;
  logic                               wr_en;
  logic [DATA_WIDTH-1:0]              data_in;
  logic [NUM_REQ-1:0]                 grant;
  logic [NUM_REQ-1:0]                 data_ack;
  logic [NUM_REQ-1:0]                 done;
  logic                               busy;

  modport master (
    input  req, burst_len, req_data, full,
    output wr_en, data_in, grant, data_ack, done, busy
  );

  modport slave (
    output req, burst_len, req_data, full,
    input  wr_en, data_in, grant, data_ack, done, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority select. It picks the first
// requester at or after index (last+1) mod N, scanning upward and wrapping.
//   req    : request vector
//   last   : index of the most recently served requester
//   winner : one-hot winner (all zero when nothing requests)
//   idx    : binary index of the winner
//   valid  : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] start;
  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   win_dbl;
  logic [N-1:0]     rot_req;
  logic [N-1:0]     rot_win;

  genvar gi, gj;

  assign start   = (last >= IDX_W'(N - 1)) ? '0 : last + 1'b1;

  // Rotate so that the highest-priority requester sits at bit 0. Then
  // isolate the lowest set bit and rotate the result back.
  assign req_dbl = {req, req};
  assign rot_req = N'(req_dbl >> start);
  assign rot_win = rot_req & (~rot_req + 1'b1);
  assign win_dbl = {{N{1'b0}}, rot_win} << start;
  assign winner  = win_dbl[N-1:0] | win_dbl[2*N-1:N];
  assign valid   = |req;

  // One-hot to binary: index bit gi is the OR of all winner positions whose
  // index has bit gi set.
  for (gi = 0; gi < IDX_W; gi++) begin : g_enc
    logic [N-1:0] mask;
    for (gj = 0; gj < N; gj++) begin : g_mask
      assign mask[gj] = ((gj >> gi) & 1) != 0;
    end
    assign idx[gi] = |(winner & mask);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Write-side arbiter for the asynchronous FIFO. It grants the FIFO write port
// to one requester at a time for an atomic burst of 1..MAX_BURST words, in
// round-robin order. Each word is stalled individually while the FIFO is
// full, so burst words are never lost or interleaved.
//   clk_wr : write-domain clock
//   rst    : asynchronous, active-high reset (aborts a burst in flight)
//   bus    : fifo_wr_arbiter_if.master. Carries requests, burst lengths and
//            requester data; the FIFO full flag and write port; and the
//            grant, data_ack, done and busy status.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int MAX_BURST = ARB_MAX_BURST,
  parameter int BL_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              clk_wr,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]   g_reg, g_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [BL_W-1:0]    cnt_reg, cnt_next;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [BL_W-1:0]    pick_len;
  logic               wr_en_int;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_masked;
  logic [DATA_WIDTH-1:0]              data_in_mux;
  logic [NUM_REQ-1:0]                 ack_vec;
  logic [NUM_REQ-1:0]                 done_vec;

  genvar gi, gb;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (last_reg),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_len  = BL_W'(arb_clamp_len(int'(bus.burst_len[pick_idx]), MAX_BURST));

  // full gates the write in the same cycle. While the write is stalled, cnt
  // holds and data_ack stays low, so the requester keeps its word.
  assign wr_en_int = (state_reg == ARB_BURST) && !bus.full;

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      g_reg     <= '0;
      cnt_reg   <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      g_reg     <= g_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    g_next     = g_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    unique case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_next = pick_onehot;
          g_next     = pick_idx;
          cnt_next   = pick_len;
          // A zero-length request still closes with a done pulse, so the
          // requester sees its request retired.
          state_next = (pick_len == '0) ? ARB_DONE : ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (wr_en_int) begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == BL_W'(1)) begin
            state_next = ARB_DONE;
          end
        end
      end
      ARB_DONE: begin
        last_next  = g_reg;
        grant_next = '0;
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // The data mux is steered by the registered grant. With no grant it
  // outputs zero.
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign data_masked[gi] = grant_reg[gi] ? bus.req_data[gi] : '0;
    assign ack_vec[gi]     = grant_reg[gi] & wr_en_int;
    assign done_vec[gi]    = grant_reg[gi] & (state_reg == ARB_DONE);
  end

  for (gb = 0; gb < DATA_WIDTH; gb++) begin : g_data_bit
    logic [NUM_REQ-1:0] col;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_col
      assign col[gi] = data_masked[gi][gb];
    end
    assign data_in_mux[gb] = |col;
  end

  assign bus.wr_en    = wr_en_int;
  assign bus.data_in  = data_in_mux;
  assign bus.grant    = grant_reg;
  assign bus.data_ack = ack_vec;
  assign bus.done     = done_vec;
  assign bus.busy     = (state_reg != ARB_IDLE);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO. Shares the FIFO write port among NUM_REQ requesters that each ask for an atomic burst of 1..MAX_BURST words. Grants one burst at a time in round-robin order and drives wr_en/data_in in the write clock domain. Stalls word-by-word on full so no burst word is ever lost or interleaved with another requester's words.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- MAX_BURST, 16: largest burst length accepted.
- BL_W, $clog2(MAX_BURST+1): width of burst-length fields.
- DATA_WIDTH: taken from fifo_pkg, not redeclared.

Ports:
- clk_wr  in  1  write-domain clock; one clock only.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester burst request (level).
- burst_len  in  NUM_REQ×BL_W  requested word count, sampled at grant.
- req_data  in  NUM_REQ×DATA_WIDTH  current word offered by each requester.
- full  in  1  FIFO full flag (clk_wr domain).
- wr_en  out  1  FIFO write enable.
- data_in  out  DATA_WIDTH  FIFO write data.
- grant  out  NUM_REQ  one-hot, registered; high for the whole burst.
- data_ack  out  NUM_REQ  one-hot; word of granted requester written this cycle.
- done  out  NUM_REQ  one-hot, one-cycle pulse at end of burst.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If any req is high, pick the winner: the first requester at or after index (last+1) mod NUM_REQ, scanning upward with wrap.
  - Register grant, latch the winner index g, and load cnt = burst_len[g].
  - If burst_len[g] == 0, go straight to DONE with no write. Otherwise go to BURST.
- BURST:
  - wr_en = !full. Combinational: full gates it in the same cycle.
  - data_in = req_data[g]. data_ack[g] = wr_en.
  - On each write, cnt decrements. A write with cnt == 1 moves to DONE.
- DONE: done[g] = 1 for one cycle, last = g, grant cleared, then IDLE.
- Requester contract: hold req_data[g] stable until data_ack[g], then present the next word by the following edge.
- Deasserting req mid-burst is ignored. The burst always completes its latched length.
- burst_len values above MAX_BURST are clamped to MAX_BURST.
- Reset values:
  - state = IDLE, grant = 0, data_ack = 0, done = 0, wr_en = 0, busy = 0, data_in = 0 (mux output with no grant).
  - cnt = 0. last = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-burst aborts the burst immediately. Partial words already in the FIFO remain. No done pulse is issued.

## Timing
- A req sampled high in IDLE at edge N gives grant high after edge N. The first wr_en is possible in cycle N+1.
- A burst of L words with no full ends with its last write in cycle N+L. done is high in cycle N+L+1, and IDLE follows in cycle N+L+2.
- Arbitration overhead: 2 non-writing cycles per burst (IDLE, DONE). Peak throughput is L/(L+2).
- Each full cycle during BURST adds exactly one cycle. cnt, data_ack and data_ack-driven requester advance all hold.
- full and a pending req from another requester in the same cycle: no effect, because the grant is locked until DONE.
- Simultaneous requests from all requesters: served in rotation. No requester waits more than NUM_REQ-1 bursts.

## Structure
- fifo_pkg (shared): DATA_WIDTH, plus the new constants ARB_NUM_REQ and ARB_MAX_BURST and typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_DONE} arb_state_t. The bench also uses these.
- One sub-module: rr_pick. Purely combinational round-robin priority select with inputs req and last, and outputs a one-hot winner and its index. It is reusable for a future read-side scheduler.
- All registers live in fifo_wr_arbiter: state, g, cnt, last, grant.

## Test plan
- Single burst: req[0] with len 4 and full = 0 → wr_en high for exactly 4 consecutive cycles starting 1 cycle after the grant. data_in follows req_data[0]. data_ack[0] ×4, then one done[0] pulse.
- Rotation: all 4 req high with len 1 → grant order 0, 1, 2, 3, 0, a grant every 3 cycles, and no two grant bits high at once.
- Backpressure: len 5, full forced high for 3 cycles after the second word → 5 writes total, 8 BURST cycles, and no wr_en while full = 1.
- Zero length: req[2] with len 0 → no wr_en and no data_ack. done[2] is pulsed 1 cycle after the grant, and the next grant goes to 3 if it is requesting.
- Clamp and drop: len 31 with MAX_BURST 16 → exactly 16 writes. req deasserted after the 3rd word → the burst still completes 16 words.
- Reset mid-burst: rst pulsed after 2 of 6 words → all outputs 0 asynchronously. The following request from req[1] and req[0] together grants 0 first.
